seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the elevator display driver. It samples the multiplexed 7-segment bus (segments plus anode selects) and recovers the per-digit hex values.
- Publishes each complete scan frame as packed digits with blank and invalid flags.
- Used in self-checking benches and as an on-board loopback monitor of the floor display.

---
 rtl/seg_scan_pkg.sv | 36 +++
 rtl/seg7_to_hex.sv | 51 +++++
 rtl/seg_scan_decoder.sv | 122 ++++++++++++
 tb/tb_seg_scan_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg_scan_pkg
// Desc     : Segment-bit indices and 7-segment pattern constants (gfedcba, active-high).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package seg_scan_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] PAT_BLANK = 7'h00;
   localparam logic [6:0] PAT_0     = 7'h3F;
   localparam logic [6:0] PAT_1     = 7'h06;
   localparam logic [6:0] PAT_2     = 7'h5B;
   localparam logic [6:0] PAT_3     = 7'h4F;
   localparam logic [6:0] PAT_4     = 7'h66;
   localparam logic [6:0] PAT_5     = 7'h6D;
   localparam logic [6:0] PAT_6     = 7'h7D;
   localparam logic [6:0] PAT_7     = 7'h07;
   localparam logic [6:0] PAT_8     = 7'h7F;
   localparam logic [6:0] PAT_9     = 7'h6F;
   localparam logic [6:0] PAT_A     = 7'h77;
   localparam logic [6:0] PAT_B     = 7'h7C;
   localparam logic [6:0] PAT_C     = 7'h39;
   localparam logic [6:0] PAT_D     = 7'h5E;
   localparam logic [6:0] PAT_E     = 7'h79;
   localparam logic [6:0] PAT_F     = 7'h71;

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg7_to_hex
// Desc     : Active-high segment pattern to {value, blank, invalid}; A-F only with SEG_SCAN_HEX_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module seg7_to_hex
   import seg_scan_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] value,
   output logic       blank,
   output logic       invalid
);

   logic [6:0] w_key;

   // Canonical gfedcba order so the table below matches the pattern constants.
   assign w_key = {seg[SEG_G], seg[SEG_F], seg[SEG_E], seg[SEG_D],
                   seg[SEG_C], seg[SEG_B], seg[SEG_A]};

   always_comb begin
      value   = 4'h0;
      blank   = 1'b0;
      invalid = 1'b0;
      case (w_key)
         PAT_BLANK: blank = 1'b1;
         PAT_0:     value = 4'h0;
         PAT_1:     value = 4'h1;
         PAT_2:     value = 4'h2;
         PAT_3:     value = 4'h3;
         PAT_4:     value = 4'h4;
         PAT_5:     value = 4'h5;
         PAT_6:     value = 4'h6;
         PAT_7:     value = 4'h7;
         PAT_8:     value = 4'h8;
         PAT_9:     value = 4'h9;
`ifdef SEG_SCAN_HEX_EN
         PAT_A:     value = 4'hA;
         PAT_B:     value = 4'hB;
         PAT_C:     value = 4'hC;
         PAT_D:     value = 4'hD;
         PAT_E:     value = 4'hE;
         PAT_F:     value = 4'hF;
`endif
         default:   invalid = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg_scan_decoder
// Desc     : Recovers per-digit hex values from a multiplexed 7-seg bus (SEG_SCAN_HEX_EN enables A-F).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int STABLE_CYCLES  = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              num_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   blank_out,
   output logic [NUM_DIGITS-1:0]   invalid_out,
   output logic                    frame_valid,
   output logic                    multi_an_err
);

   localparam int                    C_CNT_W    = 16;
   localparam logic [C_CNT_W-1:0]    C_CNT_LAST = C_CNT_W'(STABLE_CYCLES - 1);
   localparam logic [0:0]            C_SETTLE   = 1'b0;
   localparam logic [0:0]            C_HOLD     = 1'b1;
   localparam logic [NUM_DIGITS-1:0] C_ALL      = '1;

   logic [6:0]              r_seg, r_seg_q;
   logic [NUM_DIGITS-1:0]   r_an, r_an_q;
   logic [C_CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [0:0]              r_state;
   logic [NUM_DIGITS-1:0]   r_seen;
   logic [4*NUM_DIGITS-1:0] r_sh_dig;
   logic [NUM_DIGITS-1:0]   r_sh_blk, r_sh_inv;
   logic                    w_change, w_cap, w_cap_one, w_cap_multi, w_frame_done;
   logic [3:0]              w_val;
   logic                    w_blank, w_invalid;

   seg7_to_hex u_dec (
      .seg     (r_seg),
      .value   (w_val),
      .blank   (w_blank),
      .invalid (w_invalid)
   );

   assign w_change = (r_seg != r_seg_q) || (r_an != r_an_q);

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_change)
         w_cnt_nxt = '0;
      else if (r_cnt != C_CNT_LAST)
         w_cnt_nxt = r_cnt + C_CNT_W'(1);
   end

   // The capture edge is the one on which the counter arrives at its last value.
   assign w_cap        = (r_state == C_SETTLE) && !w_change && (w_cnt_nxt == C_CNT_LAST);
   assign w_cap_one    = w_cap && $onehot(r_an);
   assign w_cap_multi  = w_cap && !$onehot0(r_an);
   assign w_frame_done = (r_seen == C_ALL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seg   <= '0;
         r_seg_q <= '0;
         r_an    <= '0;
         r_an_q  <= '0;
         r_cnt   <= '0;
         r_state <= C_SETTLE;
      end else begin
         r_seg   <= SEG_ACTIVE_LOW ? ~num_in : num_in;
         r_an    <= AN_ACTIVE_LOW ? ~an_in : an_in;
         r_seg_q <= r_seg;
         r_an_q  <= r_an;
         r_cnt   <= w_cnt_nxt;
         case (r_state)
            C_SETTLE: if (w_cap)    r_state <= C_HOLD;
            default:  if (w_change) r_state <= C_SETTLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seen       <= '0;
         r_sh_dig     <= '0;
         r_sh_blk     <= '1;
         r_sh_inv     <= '0;
         digits_out   <= '0;
         blank_out    <= '1;
         invalid_out  <= '0;
         frame_valid  <= 1'b0;
         multi_an_err <= 1'b0;
      end else begin
         if (w_cap_multi)
            multi_an_err <= 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_cap_one && r_an[i]) begin
               r_sh_dig[4*i +: 4] <= w_val;
               r_sh_blk[i]        <= w_blank;
               r_sh_inv[i]        <= w_invalid;
            end
         end
         frame_valid <= w_frame_done;
         // A capture landing on the completion edge seeds the next frame.
         if (w_frame_done) begin
            digits_out  <= r_sh_dig;
            blank_out   <= r_sh_blk;
            invalid_out <= r_sh_inv;
            r_seen      <= w_cap_one ? r_an : '0;
         end else if (w_cap_one) begin
            r_seen <= r_seen | r_an;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_seg_scan_decoder
// Desc     : Directed and randomized checks of seg_scan_decoder against a window-level model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_seg_scan_decoder;

   localparam int SC = 16;
`ifdef SEG_SCAN_HEX_EN
   localparam bit HEX = 1'b1;
`else
   localparam bit HEX = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  num_in;
   logic [3:0]  an_in;
   logic [15:0] digits_out;
   logic [3:0]  blank_out, invalid_out;
   logic        frame_valid, multi_an_err;

   int          nvec = 0;
   int          nfail = 0;
   int          fv_count = 0;
   logic [23:0] obs_q[$];
   logic [23:0] exp_q[$];
   logic [6:0]  pat_tbl[16];

   logic [3:0]  m_dig[4];
   logic [3:0]  m_blk, m_inv, m_seen;
   logic        m_err;

   always #5 clk = ~clk;

   seg_scan_decoder #(
      .NUM_DIGITS     (4),
      .STABLE_CYCLES  (SC),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .num_in       (num_in),
      .an_in        (an_in),
      .digits_out   (digits_out),
      .blank_out    (blank_out),
      .invalid_out  (invalid_out),
      .frame_valid  (frame_valid),
      .multi_an_err (multi_an_err)
   );

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         fv_count++;
         obs_q.push_back({digits_out, blank_out, invalid_out});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {value, blank, invalid} from the pattern list.
   function automatic logic [5:0] ref_decode(input logic [6:0] p);
      if (p == 7'h00) return {4'h0, 1'b1, 1'b0};
      for (int v = 0; v < 16; v++)
         if (p == pat_tbl[v] && (v < 10 || HEX)) return {4'(v), 1'b0, 1'b0};
      return {4'h0, 1'b0, 1'b1};
   endfunction

   // Drive one window (active-high view) for len cycles, starting at a falling edge.
   task automatic win(input logic [3:0] an, input logic [6:0] seg, input int len);
      num_in = ~seg;
      an_in  = ~an;
      repeat (len) @(negedge clk);
   endtask

   task automatic mwin(input logic [3:0] an, input logic [6:0] seg, input int len);
      logic [5:0] d;
      win(an, seg, len);
      if (len >= SC && an != 4'h0) begin
         if ($countones(an) > 1) begin
            m_err = 1'b1;
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (an[k]) begin
                  d         = ref_decode(seg);
                  m_dig[k]  = d[5:2];
                  m_blk[k]  = d[1];
                  m_inv[k]  = d[0];
                  m_seen[k] = 1'b1;
               end
            end
            if (m_seen == 4'hF) begin
               exp_q.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_blk, m_inv});
               m_seen = 4'h0;
            end
         end
      end
   endtask

   initial begin
      logic [3:0]  ran;
      logic [6:0]  rsg;
      logic [10:0] prev;
      int          len, r, n;

      pat_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      reset  = 1'b0;
      num_in = 7'h7F;
      an_in  = 4'hF;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("rst_digits",  digits_out,   16'h0000);
      check("rst_blank",   blank_out,    4'hF);
      check("rst_invalid", invalid_out,  4'h0);
      check("rst_fv",      frame_valid,  1'b0);
      check("rst_err",     multi_an_err, 1'b0);
      check("rst_frames",  fv_count,     0);

      // Normal scan 1,2,3,4 with the latency of the final slot checked edge by edge.
      win(4'b0001, 7'h06, 20);
      win(4'b0010, 7'h5B, 20);
      win(4'b0100, 7'h4F, 20);
      num_in = ~7'h66;
      an_in  = ~4'b1000;
      repeat (17) @(negedge clk);
      check("lat_early", frame_valid, 1'b0);
      @(negedge clk);
      check("lat_fv", frame_valid, 1'b1);
      check("scan_digits",  digits_out,  16'h4321);
      check("scan_blank",   blank_out,   4'h0);
      check("scan_invalid", invalid_out, 4'h0);
      @(negedge clk);
      check("fv_single", frame_valid, 1'b0);
      win(4'h0, 7'h00, 30);
      check("scan_frames", fv_count, 1);

      // Glitch rejection: 15 stable cycles miss, exactly 16 capture.
      win(4'b0010, 7'h7D, 20);
      win(4'b0100, 7'h07, 20);
      win(4'b1000, 7'h7F, 20);
      win(4'b0001, 7'h6F, 15);
      win(4'h0, 7'h00, 30);
      check("glitch_frames", fv_count, 1);
      check("glitch_hold",   digits_out, 16'h4321);
      win(4'b0001, 7'h6F, 16);
      win(4'h0, 7'h00, 30);
      check("stable16_frames", fv_count, 2);
      check("stable16_digits", digits_out, 16'h8769);

      // Blank, invalid and hex pattern.
      win(4'b1000, 7'h00, 20);
      win(4'b0100, 7'h01, 20);
      win(4'b0010, 7'h5B, 20);
      win(4'b0001, 7'h77, 20);
      win(4'h0, 7'h00, 30);
      check("bi_frames",  fv_count, 3);
      check("bi_digits",  digits_out, HEX ? 16'h002A : 16'h0020);
      check("bi_blank",   blank_out, 4'b1000);
      check("bi_invalid", invalid_out, HEX ? 4'b0100 : 4'b0101);

      // Two anodes at once: sticky error, and the window captures nothing.
      win(4'b0010, 7'h06, 20);
      win(4'b0100, 7'h06, 20);
      win(4'b1000, 7'h06, 20);
      win(4'b0011, 7'h7F, 20);
      win(4'h0, 7'h00, 30);
      check("multi_err",    multi_an_err, 1'b1);
      check("multi_frames", fv_count, 3);
      win(4'b0001, 7'h3F, 20);
      win(4'h0, 7'h00, 30);
      check("multi_after_frames", fv_count, 4);
      check("multi_after_digits", digits_out, 16'h1110);
      check("multi_sticky",       multi_an_err, 1'b1);

      // Reset after two captured slots discards the partial frame.
      win(4'b0001, 7'h66, 20);
      win(4'b0010, 7'h6D, 20);
      reset = 1'b0;
      #1;
      check("mid_rst_digits",  digits_out,   16'h0000);
      check("mid_rst_blank",   blank_out,    4'hF);
      check("mid_rst_invalid", invalid_out,  4'h0);
      check("mid_rst_fv",      frame_valid,  1'b0);
      check("mid_rst_err",     multi_an_err, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      win(4'b0100, 7'h7D, 20);
      win(4'b1000, 7'h07, 20);
      win(4'h0, 7'h00, 30);
      check("mid_rst_noframe", fv_count, 4);
      win(4'b0001, 7'h7F, 20);
      win(4'b0010, 7'h6F, 20);
      win(4'h0, 7'h00, 30);
      check("mid_rst_frames", fv_count, 5);
      check("mid_rst_new",    digits_out, 16'h7698);

      // Randomized windows against the window-level model.
      reset  = 1'b0;
      num_in = 7'h7F;
      an_in  = 4'hF;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      obs_q.delete();
      m_seen = 4'h0;
      m_err  = 1'b0;
      m_blk  = 4'hF;
      m_inv  = 4'h0;
      for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
      prev = 11'h0;
      for (int w = 0; w < 80; w++) begin
         do begin
            r   = $urandom_range(0, 19);
            ran = (r == 0) ? 4'h0 :
                  (r == 1) ? 4'($urandom_range(0, 15)) :
                             4'(1 << $urandom_range(0, 3));
            r   = $urandom_range(0, 9);
            rsg = (r < 7)  ? pat_tbl[$urandom_range(0, 15)] :
                  (r == 7) ? 7'h00 : 7'($urandom);
         end while ({ran, rsg} == prev);
         r   = $urandom_range(0, 9);
         len = (r < 6)  ? int'($urandom_range(17, 26)) :
               (r == 6) ? 16 :
               (r == 7) ? 15 : int'($urandom_range(1, 14));
         mwin(ran, rsg, len);
         prev = {ran, rsg};
      end
      win(4'h0, 7'h00, 30);
      check("rnd_frames", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check("rnd_frame", obs_q[i], exp_q[i]);
      check("rnd_err", multi_an_err, m_err);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
